instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Base_Ld, input, 1, loads Base_Addr into the address counter (IDLE only).
REQ-004 SHALL have port Base_Addr, input, 32, start word address of program image.
REQ-005 SHALL have port In_Valid, input, 1, mnemonic record valid.
REQ-006 SHALL have port In_Ready, output, 1, encoder accepts a record this cycle.
REQ-007 SHALL have port In_Op, input, 4, mnemonic: 0 ALU, 1 lw, 2 lb, 3 sw, 4 b, 5 beq, 6 bne, 7 li, 8 addi, 9 andi, 10 ori; 11-15 illegal.
REQ-008 SHALL have ports In_Rs, In_Rd and In_Rt, input, 5 each, register fields.
REQ-009 SHALL have port In_Imm, input, 16, immediate; port In_Func, input, 4, ALU function.
REQ-010 SHALL have port Out_Valid, output, 1, encoded word valid; port Out_Ready, input, 1, instruction-memory writer accepts.
REQ-011 SHALL have port Out_Instr, output, 32, encoded instruction; port Out_Addr, output, 32, its byte address.
REQ-012 SHALL have port Err, output, 1, sticky illegal-input flag; port Err_Clr, input, 1, clears Err.
REQ-013 SHALL have port Count, output, 16, number of words emitted since reset/Base_Ld, saturating at 16'hFFFF.

Function
REQ-014 SHALL encode opcode in [31:26]: ALU 100000, lw 001111, lb 000011, sw 011111, b 111111, beq 000000, bne 000001, li 111000, addi 110000, andi 110010, ori 110011.
REQ-015 SHALL place Rs in [25:21], Rd in [20:16]; ALU: Rt in [15:11], zeros [10:4], In_Func in [3:0]; all others: In_Imm in [15:0].
REQ-016 SHALL force unused fields to zero: b drops Rs/Rd; li drops Rs.
REQ-017 SHALL implement FSM IDLE -> RUN on first accepted record; RUN -> ERR on illegal In_Op; ERR -> IDLE on Err_Clr; RUN -> IDLE on Base_Ld when Out_Valid=0.
REQ-018 SHALL drive In_Ready = (state != ERR) && (!Out_Valid || Out_Ready): one-entry pipeline register, full throughput.
REQ-019 SHALL present Out_Instr/Out_Addr one cycle after In_Valid&&In_Ready; hold them stable while Out_Valid&&!Out_Ready.
REQ-020 SHALL increment the address counter by 4 on each accepted legal record; wrap 32'hFFFFFFFC -> 0 silently.
REQ-021 SHALL drop an illegal record (no Out_Valid), set Err, leave counter unchanged.
REQ-022 SHALL ignore Base_Ld outside IDLE; Base_Ld and In_Valid in the same IDLE cycle: load first, record gets Base_Addr.
REQ-023 SHALL give Err_Clr priority over a simultaneous illegal record (Err stays 0, record dropped).

Reset
REQ-024 SHALL on Reset_n low: state IDLE, Out_Valid 0, Out_Instr 0, Out_Addr 0, counter 0, Count 0, Err 0, In_Ready 0 while asserted.
REQ-025 SHALL discard any in-flight word on reset mid-operation; no partial handshake completes.

Configuration
REQ-026 SHALL, with ENC_R0_CHECK_EN defined, treat writes to register 0 (Rd=0 on ALU, lw, lb, li, addi, andi, ori) as illegal per REQ-021.
REQ-027 SHALL, without ENC_R0_CHECK_EN, encode such records normally.

Structure
REQ-028 SHALL take opcode constants, In_Op codes and field bit positions from shared package instr_enc_pkg; the control decoder uses the same constants.
REQ-029 SHALL isolate mnemonic-to-word mapping in combinational sub-module instr_field_pack; FSM, counter, handshake stay in instr_encoder.

Verification
REQ-030 SHALL cover: Base_Ld 0x100, addi Rs=1 Rd=2 Imm=0x0005 -> Out_Instr 0xC0220005 at Out_Addr 0x100, next record at 0x104.
REQ-031 SHALL cover: ALU Rs=3 Rd=4 Rt=5 Func=0x2 -> Out_Instr 0x80642802; b Imm=0xFFFE -> 0xFC00FFFE.
REQ-032 SHALL cover: Out_Ready low 3 cycles with In_Valid high -> Out_Instr stable, In_Ready 0, no record lost, Count +1 per handshake.
REQ-033 SHALL cover: In_Op=12 -> Err=1, In_Ready=0, no output; Err_Clr -> IDLE, Err=0, counter unchanged.
REQ-034 SHALL cover: Base_Ld 0xFFFFFFFC, two records -> addresses 0xFFFFFFFC then 0x00000000.
REQ-035 SHALL cover: Reset_n pulsed while Out_Valid=1 -> Out_Valid 0 immediately, Count 0; li Rd=0 flags Err only with ENC_R0_CHECK_EN.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared constants for the instruction encoder: mnemonic codes, opcodes, field positions, FSM states.
// Build with ENC_R0_CHECK_EN defined to reject records that write register 0.
package instr_enc_pkg;

    typedef enum logic [3:0] {
        OP_ALU  = 4'd0,
        OP_LW   = 4'd1,
        OP_LB   = 4'd2,
        OP_SW   = 4'd3,
        OP_B    = 4'd4,
        OP_BEQ  = 4'd5,
        OP_BNE  = 4'd6,
        OP_LI   = 4'd7,
        OP_ADDI = 4'd8,
        OP_ANDI = 4'd9,
        OP_ORI  = 4'd10
    } in_op_e;

    localparam logic [5:0] OPC_ALU  = 6'b100000;
    localparam logic [5:0] OPC_LW   = 6'b001111;
    localparam logic [5:0] OPC_LB   = 6'b000011;
    localparam logic [5:0] OPC_SW   = 6'b011111;
    localparam logic [5:0] OPC_B    = 6'b111111;
    localparam logic [5:0] OPC_BEQ  = 6'b000000;
    localparam logic [5:0] OPC_BNE  = 6'b000001;
    localparam logic [5:0] OPC_LI   = 6'b111000;
    localparam logic [5:0] OPC_ADDI = 6'b110000;
    localparam logic [5:0] OPC_ANDI = 6'b110010;
    localparam logic [5:0] OPC_ORI  = 6'b110011;

    localparam int OPC_LSB  = 26;
    localparam int RS_LSB   = 21;
    localparam int RD_LSB   = 16;
    localparam int RT_LSB   = 11;
    localparam int FUNC_LSB = 0;
    localparam int IMM_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } enc_state_e;

    // Mnemonics whose Rd field names a destination register
    function automatic logic writes_rd(input logic [3:0] op);
        logic w;
        case (op)
            OP_ALU, OP_LW, OP_LB, OP_LI, OP_ADDI, OP_ANDI, OP_ORI: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Record-in / encoded-word-out handshake bundle of the instruction encoder.
interface instr_encoder_if;

    logic        In_Valid;
    logic        In_Ready;
    logic [3:0]  In_Op;
    logic [4:0]  In_Rs;
    logic [4:0]  In_Rd;
    logic [4:0]  In_Rt;
    logic [15:0] In_Imm;
    logic [3:0]  In_Func;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Instr;
    logic [31:0] Out_Addr;

    modport master (
        output In_Valid, In_Op, In_Rs, In_Rd, In_Rt, In_Imm, In_Func, Out_Ready,
        input  In_Ready, Out_Valid, Out_Instr, Out_Addr
    );

    modport slave (
        input  In_Valid, In_Op, In_Rs, In_Rd, In_Rt, In_Imm, In_Func, Out_Ready,
        output In_Ready, Out_Valid, Out_Instr, Out_Addr
    );

endinterface

// File: rtl/instr_field_pack.sv
// Combinational mnemonic-to-word mapping; flags records that cannot be encoded.
// With ENC_R0_CHECK_EN defined, a register-0 destination is also flagged.
module instr_field_pack
    import instr_enc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rd,
    input  logic [4:0]  rt,
    input  logic [15:0] imm,
    input  logic [3:0]  func,
    output logic [31:0] instr,
    output logic        illegal
);

    logic [5:0]  opc_s;
    logic [4:0]  rs_s;
    logic [4:0]  rd_s;
    logic [15:0] lo_s;
    logic        bad_s;

    // Select opcode and mask fields the mnemonic does not use
    always_comb begin
        opc_s = 6'd0;
        rs_s  = rs;
        rd_s  = rd;
        lo_s  = imm;
        bad_s = 1'b0;
        case (op)
            OP_ALU: begin
                opc_s = OPC_ALU;
                lo_s  = 16'd0;
                lo_s[RT_LSB +: 5]   = rt;
                lo_s[FUNC_LSB +: 4] = func;
            end
            OP_LW:   opc_s = OPC_LW;
            OP_LB:   opc_s = OPC_LB;
            OP_SW:   opc_s = OPC_SW;
            OP_B: begin
                opc_s = OPC_B;
                rs_s  = 5'd0;
                rd_s  = 5'd0;
            end
            OP_BEQ:  opc_s = OPC_BEQ;
            OP_BNE:  opc_s = OPC_BNE;
            OP_LI: begin
                opc_s = OPC_LI;
                rs_s  = 5'd0;
            end
            OP_ADDI: opc_s = OPC_ADDI;
            OP_ANDI: opc_s = OPC_ANDI;
            OP_ORI:  opc_s = OPC_ORI;
            default: begin
                rs_s  = 5'd0;
                rd_s  = 5'd0;
                lo_s  = 16'd0;
                bad_s = 1'b1;
            end
        endcase
    end

    // Assemble the word from the package field positions
    always_comb begin
        instr = 32'd0;
        instr[OPC_LSB +: 6]  = opc_s;
        instr[RS_LSB +: 5]   = rs_s;
        instr[RD_LSB +: 5]   = rd_s;
        instr[IMM_LSB +: 16] = lo_s;
    end

`ifdef ENC_R0_CHECK_EN
    assign illegal = bad_s | (writes_rd(op) & (rd == 5'd0));
`else
    assign illegal = bad_s;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: FSM, address counter, word counter and one-entry output register.
// Register-0 destination checking is enabled by defining ENC_R0_CHECK_EN.
module instr_encoder
    import instr_enc_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Base_Ld,
    input  logic [31:0] Base_Addr,
    input  logic        Err_Clr,
    output logic        Err,
    output logic [15:0] Count,
    instr_encoder_if.slave bus
);

    enc_state_e  state_r;
    enc_state_e  state_s;
    logic [31:0] addr_r;
    logic        out_valid_r;
    logic [31:0] out_instr_r;
    logic [31:0] out_addr_r;
    logic        err_r;
    logic [15:0] count_r;

    logic [31:0] packed_s;
    logic        illegal_s;
    logic        in_ready_s;
    logic        in_fire_s;
    logic        accept_s;
    logic        flag_s;
    logic        load_s;
    logic        out_fire_s;
    logic [31:0] base_s;

    instr_field_pack u_pack (
        .op      (bus.In_Op),
        .rs      (bus.In_Rs),
        .rd      (bus.In_Rd),
        .rt      (bus.In_Rt),
        .imm     (bus.In_Imm),
        .func    (bus.In_Func),
        .instr   (packed_s),
        .illegal (illegal_s)
    );

    // Reset_n gates In_Ready so nothing is accepted while reset is held
    assign in_ready_s = Reset_n && (state_r != ST_ERR) && (!out_valid_r || bus.Out_Ready);
    assign in_fire_s  = bus.In_Valid && in_ready_s;
    assign accept_s   = in_fire_s && !illegal_s;
    assign flag_s     = in_fire_s && illegal_s && !Err_Clr;
    assign load_s     = Base_Ld && (state_r == ST_IDLE);
    assign out_fire_s = out_valid_r && bus.Out_Ready;
    assign base_s     = load_s ? Base_Addr : addr_r;

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flag_s)        state_s = ST_ERR;
                else if (accept_s) state_s = ST_RUN;
                else               state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (flag_s)                        state_s = ST_ERR;
                else if (Base_Ld && !out_valid_r)  state_s = ST_IDLE;
                else                               state_s = ST_RUN;
            end
            ST_ERR: begin
                if (Err_Clr) state_s = ST_IDLE;
                else         state_s = ST_ERR;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_r <= ST_IDLE;
        else          state_r <= state_s;
    end

    // Address counter; 32-bit add wraps 0xFFFFFFFC to 0
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)      addr_r <= 32'd0;
        else if (accept_s) addr_r <= base_s + 32'd4;
        else if (load_s)   addr_r <= Base_Addr;
        else               addr_r <= addr_r;
    end

    // Output pipeline register, held while the writer stalls
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'd0;
            out_addr_r  <= 32'd0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_instr_r <= packed_s;
            out_addr_r  <= base_s;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Sticky error flag; clear wins over a simultaneous illegal record
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)     err_r <= 1'b0;
        else if (Err_Clr) err_r <= 1'b0;
        else if (flag_s)  err_r <= 1'b1;
        else              err_r <= err_r;
    end

    // Saturating count of words handed to the writer
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                                count_r <= 16'd0;
        else if (load_s)                             count_r <= 16'd0;
        else if (out_fire_s && count_r != 16'hFFFF)  count_r <= count_r + 16'd1;
        else                                         count_r <= count_r;
    end

    assign bus.In_Ready  = in_ready_s;
    assign bus.Out_Valid = out_valid_r;
    assign bus.Out_Instr = out_instr_r;
    assign bus.Out_Addr  = out_addr_r;
    assign Err           = err_r;
    assign Count         = count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: inputs change on the falling edge, outputs are checked there.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        base_ld;
    logic [31:0] base_addr;
    logic        err_clr;
    logic        err;
    logic [15:0] count;
    int          n_checks;
    int          n_errors;

    instr_encoder_if enc_if ();

    instr_encoder dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .Base_Ld   (base_ld),
        .Base_Addr (base_addr),
        .Err_Clr   (err_clr),
        .Err       (err),
        .Count     (count),
        .bus       (enc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rec(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rd,
                       input logic [4:0] rt, input logic [15:0] imm, input logic [3:0] func);
        enc_if.In_Op    = op;
        enc_if.In_Rs    = rs;
        enc_if.In_Rd    = rd;
        enc_if.In_Rt    = rt;
        enc_if.In_Imm   = imm;
        enc_if.In_Func  = func;
        enc_if.In_Valid = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        base_ld = 1'b0;
        base_addr = 32'd0;
        err_clr = 1'b0;
        enc_if.In_Valid = 1'b0;
        enc_if.In_Op = 4'd0;
        enc_if.In_Rs = 5'd0;
        enc_if.In_Rd = 5'd0;
        enc_if.In_Rt = 5'd0;
        enc_if.In_Imm = 16'd0;
        enc_if.In_Func = 4'd0;
        enc_if.Out_Ready = 1'b1;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, enc_if.Out_Valid}, 32'd0);
        chk("rst_out_instr", enc_if.Out_Instr, 32'd0);
        chk("rst_out_addr", enc_if.Out_Addr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        chk("rst_in_ready", {31'd0, enc_if.In_Ready}, 32'd0);
        rst_n = 1'b1;

        // load base and first record in the same IDLE cycle
        @(negedge clk);
        base_ld = 1'b1;
        base_addr = 32'h0000_0100;
        rec(4'd8, 5'd1, 5'd2, 5'd0, 16'h0005, 4'd0);
        #1 chk("idle_in_ready", {31'd0, enc_if.In_Ready}, 32'd1);
        @(negedge clk);
        base_ld = 1'b0;
        chk("addi_valid", {31'd0, enc_if.Out_Valid}, 32'd1);
        chk("addi_instr", enc_if.Out_Instr, 32'hC022_0005);
        chk("addi_addr", enc_if.Out_Addr, 32'h0000_0100);
        rec(4'd0, 5'd3, 5'd4, 5'd5, 16'h0000, 4'h2);
        @(negedge clk);
        chk("alu_instr", enc_if.Out_Instr, 32'h8064_2802);
        chk("alu_addr", enc_if.Out_Addr, 32'h0000_0104);
        chk("alu_count", {16'd0, count}, 32'd1);
        rec(4'd4, 5'd9, 5'd9, 5'd0, 16'hFFFE, 4'd0);
        @(negedge clk);
        chk("b_instr", enc_if.Out_Instr, 32'hFC00_FFFE);
        chk("b_addr", enc_if.Out_Addr, 32'h0000_0108);
        chk("b_count", {16'd0, count}, 32'd2);

        // writer stalls for three cycles with a record waiting
        enc_if.Out_Ready = 1'b0;
        rec(4'd1, 5'd6, 5'd7, 5'd0, 16'h1234, 4'd0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_in_ready", {31'd0, enc_if.In_Ready}, 32'd0);
            @(negedge clk);
            chk("stall_instr", enc_if.Out_Instr, 32'hFC00_FFFE);
            chk("stall_addr", enc_if.Out_Addr, 32'h0000_0108);
            chk("stall_count", {16'd0, count}, 32'd2);
        end
        enc_if.Out_Ready = 1'b1;
        #1 chk("unstall_in_ready", {31'd0, enc_if.In_Ready}, 32'd1);
        @(negedge clk);
        chk("lw_instr", enc_if.Out_Instr, 32'h3CC7_1234);
        chk("lw_addr", enc_if.Out_Addr, 32'h0000_010C);
        chk("lw_count", {16'd0, count}, 32'd3);
        enc_if.In_Valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", {31'd0, enc_if.Out_Valid}, 32'd0);
        chk("drain_count", {16'd0, count}, 32'd4);

        // illegal mnemonic locks the encoder until Err_Clr
        rec(4'd12, 5'd1, 5'd1, 5'd1, 16'h1111, 4'd1);
        @(negedge clk);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_valid", {31'd0, enc_if.Out_Valid}, 32'd0);
        chk("ill_in_ready", {31'd0, enc_if.In_Ready}, 32'd0);
        rec(4'd10, 5'd1, 5'd2, 5'd0, 16'h00AA, 4'd0);
        @(negedge clk);
        chk("err_hold_valid", {31'd0, enc_if.Out_Valid}, 32'd0);
        chk("err_hold_err", {31'd0, err}, 32'd1);
        enc_if.In_Valid = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("clr_in_ready", {31'd0, enc_if.In_Ready}, 32'd1);
        rec(4'd3, 5'd8, 5'd9, 5'd0, 16'h0010, 4'd0);
        @(negedge clk);
        chk("sw_instr", enc_if.Out_Instr, 32'h7D09_0010);
        chk("sw_addr", enc_if.Out_Addr, 32'h0000_0110);
        enc_if.In_Valid = 1'b0;
        @(negedge clk);
        chk("sw_count", {16'd0, count}, 32'd5);

        // Err_Clr beats a simultaneous illegal record
        rec(4'd15, 5'd0, 5'd0, 5'd0, 16'h0000, 4'd0);
        err_clr = 1'b1;
        @(negedge clk);
        chk("prio_err", {31'd0, err}, 32'd0);
        chk("prio_valid", {31'd0, enc_if.Out_Valid}, 32'd0);
        chk("prio_in_ready", {31'd0, enc_if.In_Ready}, 32'd1);
        enc_if.In_Valid = 1'b0;
        err_clr = 1'b0;

        // address wrap: first Base_Ld leaves RUN, second loads
        base_ld = 1'b1;
        base_addr = 32'hFFFF_FFFC;
        @(negedge clk);
        rec(4'd9, 5'd2, 5'd3, 5'd0, 16'h00FF, 4'd0);
        @(negedge clk);
        base_ld = 1'b0;
        chk("wrap0_instr", enc_if.Out_Instr, 32'hC843_00FF);
        chk("wrap0_addr", enc_if.Out_Addr, 32'hFFFF_FFFC);
        chk("wrap0_count", {16'd0, count}, 32'd0);
        rec(4'd10, 5'd4, 5'd5, 5'd0, 16'hABCD, 4'd0);
        @(negedge clk);
        chk("wrap1_instr", enc_if.Out_Instr, 32'hCC85_ABCD);
        chk("wrap1_addr", enc_if.Out_Addr, 32'h0000_0000);
        chk("wrap1_count", {16'd0, count}, 32'd1);

        // reset while a word is pending
        enc_if.In_Valid = 1'b0;
        enc_if.Out_Ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, enc_if.Out_Valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, enc_if.Out_Valid}, 32'd0);
        chk("mid_rst_count", {16'd0, count}, 32'd0);
        chk("mid_rst_addr", enc_if.Out_Addr, 32'd0);
        chk("mid_rst_in_ready", {31'd0, enc_if.In_Ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        enc_if.Out_Ready = 1'b1;

        // li to register 0
        @(negedge clk);
        rec(4'd7, 5'd7, 5'd0, 5'd0, 16'h0042, 4'd0);
        @(negedge clk);
        enc_if.In_Valid = 1'b0;
`ifdef ENC_R0_CHECK_EN
        chk("li_r0_err", {31'd0, err}, 32'd1);
        chk("li_r0_valid", {31'd0, enc_if.Out_Valid}, 32'd0);
`else
        chk("li_r0_err", {31'd0, err}, 32'd0);
        chk("li_r0_valid", {31'd0, enc_if.Out_Valid}, 32'd1);
        chk("li_r0_instr", enc_if.Out_Instr, 32'hE000_0042);
        chk("li_r0_addr", enc_if.Out_Addr, 32'h0000_0000);
`endif
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
